down_sampler_sym: RTL



---
 rtl/down_sampler_pkg.sv | 20 ++
 rtl/ds_phase_counter.sv | 44 ++++
 rtl/down_sampler_sym.sv | 111 +++++++++++
 3 files changed

// File: rtl/down_sampler_pkg.sv
// Shared types and elaboration helpers for the symbol-rate down-sampler.
package down_sampler_pkg;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  function automatic int log2_ceil(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/ds_phase_counter.sv
// Sample-index counter: aligns to sym_clk, reports the current index/wrap and
// pulses slip when a strobe lands on a non-zero index while locked.
module ds_phase_counter
  import down_sampler_pkg::*;
#(
  parameter int FACTOR = 4,
  parameter int PH_W   = log2_ceil(FACTOR)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sam_clk,
  input  logic            sym_clk,
  input  logic            locked,
  output logic [PH_W-1:0] idx,
  output logic            wrap,
  output logic            realign,
  output logic            slip
);

  logic [PH_W-1:0] cnt_reg;
  logic            slip_reg;

  // A strobed sample is index 0 regardless of where the counter was.
  always_comb begin
    idx     = sym_clk ? '0 : cnt_reg;
    wrap    = (idx == PH_W'(FACTOR - 1));
    realign = locked & sam_clk & sym_clk & (cnt_reg != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg  <= '0;
      slip_reg <= 1'b0;
    end else begin
      slip_reg <= realign;
      // In SEARCH the counter only moves on the strobe that locks us.
      if (sam_clk && (locked || sym_clk))
        cnt_reg <= idx + PH_W'(1);
    end
  end

  assign slip = slip_reg;

endmodule

// File: rtl/down_sampler_sym.sv
// Receive-side decimator: one sample per symbol at a selectable phase.
// Define DOWN_SAMPLER_INTEG_EN for integrate-and-dump instead of phase select.
module down_sampler_sym
  import down_sampler_pkg::*;
#(
  parameter int WIDTH  = 18,
  parameter int FACTOR = 4,
  parameter int PH_W   = log2_ceil(FACTOR)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sam_clk,
  input  logic                    sym_clk,
  input  logic [PH_W-1:0]         phase,
  input  logic signed [WIDTH-1:0] x_in,
  output logic signed [WIDTH-1:0] y,
  output logic                    y_valid,
  output logic                    slip,
  output logic                    locked
);

  if (!is_pow2(FACTOR)) begin : g_bad_factor
    $error("down_sampler_sym: FACTOR must be a power of two >= 2");
  end

  state_t            state_reg;
  logic [WIDTH-1:0]  y_reg;
  logic              y_valid_reg;
  logic [PH_W-1:0]   idx;
  logic              wrap;
  logic              realign;
  logic              active;

  assign locked = (state_reg == ST_LOCKED);
  // The locking sample itself is processed as index 0.
  assign active = sam_clk & (locked | sym_clk);

  ds_phase_counter #(
    .FACTOR (FACTOR),
    .PH_W   (PH_W)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .sam_clk (sam_clk),
    .sym_clk (sym_clk),
    .locked  (locked),
    .idx     (idx),
    .wrap    (wrap),
    .realign (realign),
    .slip    (slip)
  );

`ifdef DOWN_SAMPLER_INTEG_EN
  localparam int ACC_W = WIDTH + PH_W;

  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_sum;

  // Index 0 (including a realigning strobe) drops any partial sum.
  always_comb begin
    acc_base = (idx == '0) ? '0 : acc_reg;
    acc_sum  = acc_base + {{PH_W{x_in[WIDTH-1]}}, x_in};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_SEARCH;
      y_reg       <= '0;
      y_valid_reg <= 1'b0;
      acc_reg     <= '0;
    end else begin
      y_valid_reg <= 1'b0;
      case (state_reg)
        ST_SEARCH: if (sam_clk && sym_clk) state_reg <= ST_LOCKED;
        default:   state_reg <= ST_LOCKED;
      endcase
      if (active) begin
        acc_reg <= acc_sum;
        if (wrap) begin
          // Slicing off the low PH_W bits is an arithmetic shift toward -inf.
          y_reg       <= acc_sum[ACC_W-1:PH_W];
          y_valid_reg <= 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_SEARCH;
      y_reg       <= '0;
      y_valid_reg <= 1'b0;
    end else begin
      y_valid_reg <= 1'b0;
      case (state_reg)
        ST_SEARCH: if (sam_clk && sym_clk) state_reg <= ST_LOCKED;
        default:   state_reg <= ST_LOCKED;
      endcase
      if (active && (idx == phase)) begin
        y_reg       <= x_in;
        y_valid_reg <= 1'b1;
      end
    end
  end
`endif

  assign y       = y_reg;
  assign y_valid = y_valid_reg;

endmodule
